// File: rtl/decoder_2to4_pkg.sv
// Shared widths and the active-high one-hot decode used by the decoder and its bench.
package decoder_2to4_pkg;

    localparam int unsigned SEL_W = 2;
    localparam int unsigned OUT_W = 4;

    // Bit k of the result is set when sel == k.
    function automatic logic [OUT_W-1:0] onehot_decode(input logic [SEL_W-1:0] sel);
        return OUT_W'(1) << sel;
    endfunction

endpackage

// File: rtl/decoder_2to4_core.sv
// Combinational select-to-one-hot stage with the output polarity folded in.
module decoder_2to4_core
    import decoder_2to4_pkg::*;
#(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic [SEL_W-1:0] sel_i,
    output logic [OUT_W-1:0] word_o
);

    logic [OUT_W-1:0] onehot;

    assign onehot = onehot_decode(sel_i);
    assign word_o = OUT_ACTIVE_LOW ? ~onehot : onehot;

endmodule

// File: rtl/decoder_2to4.sv
// Registered 2-to-4 one-hot decoder with enable, optional hold, valid strobe and idle flag.
module decoder_2to4
    import decoder_2to4_pkg::*;
#(
    parameter bit OUT_ACTIVE_LOW     = 1'b0,
    parameter bit HOLD_WHEN_DISABLED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEL_W-1:0] in,
    output logic [OUT_W-1:0] out,
    output logic             valid,
    output logic             idle
);

    localparam logic [OUT_W-1:0] IDLE_PAT = OUT_ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    logic [OUT_W-1:0] word;
    logic [OUT_W-1:0] out_d, out_q;
    logic             valid_d, valid_q;

    decoder_2to4_core #(
        .OUT_ACTIVE_LOW(OUT_ACTIVE_LOW)
    ) u_core (
        .sel_i (in),
        .word_o(word)
    );

    // Enable/hold selection of the next output word.
    always_comb begin
        out_d   = IDLE_PAT;
        valid_d = 1'b0;
        if (en) begin
            out_d   = word;
            valid_d = 1'b1;
        end else if (HOLD_WHEN_DISABLED) begin
            out_d   = out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= IDLE_PAT;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign idle  = (out_q == IDLE_PAT);

endmodule

// File: tb/tb_decoder_2to4.sv
// Self-checking bench: four decoder variants (polarity x hold) driven in parallel against a reference model.
module tb_decoder_2to4;
    import decoder_2to4_pkg::*;

    localparam logic [3:0] HI_TBL [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    localparam logic [3:0] LO_TBL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [1:0] sel = 2'b00;

    logic [3:0] dut_out [4];
    logic [3:0] dut_val;
    logic [3:0] dut_idle;

    logic [3:0] exp_out [4];
    logic [3:0] exp_val;
    logic       known = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Index bit0 = active-low polarity, bit1 = hold when disabled.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        decoder_2to4 #(
            .OUT_ACTIVE_LOW    (1'(g % 2)),
            .HOLD_WHEN_DISABLED(1'(g / 2))
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en),
            .in   (sel),
            .out  (dut_out[g]),
            .valid(dut_val[g]),
            .idle (dut_idle[g])
        );
    end

    function automatic logic [3:0] idle_of(input int i);
        return (i % 2 == 1) ? 4'b1111 : 4'b0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what each variant must show after every edge.
    always @(posedge clk) begin
        if (!rst_n) known <= 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                exp_out[i] <= idle_of(i);
                exp_val[i] <= 1'b0;
            end else if (en) begin
                exp_out[i] <= onehot_decode(sel) ^ idle_of(i);
                exp_val[i] <= 1'b1;
            end else begin
                exp_out[i] <= (i / 2 == 1) ? exp_out[i] : idle_of(i);
                exp_val[i] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (known) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("out[%0d]", i), 32'(dut_out[i]), 32'(exp_out[i]));
                chk($sformatf("valid[%0d]", i), 32'(dut_val[i]), 32'(exp_val[i]));
                chk($sformatf("idle[%0d]", i), 32'(dut_idle[i]), 32'(exp_out[i] == idle_of(i)));
                if (dut_val[i])
                    chk($sformatf("onehot[%0d]", i), 32'($countones(dut_out[i] ^ idle_of(i))), 32'd1);
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic [1:0] s);
        rst_n = r;
        en    = e;
        sel   = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Pin the package decode against hand-written words.
        for (int k = 0; k < 4; k++)
            chk($sformatf("pkg_decode[%0d]", k), 32'(onehot_decode(2'(k))), 32'(HI_TBL[k]));

        @(negedge clk);
        step(1'b0, 1'b1, 2'b11);
        step(1'b0, 1'b1, 2'b11);
        chk("rst_out_hi", 32'(dut_out[0]), 32'h0);
        chk("rst_valid", 32'(dut_val[0]), 32'h0);
        chk("rst_idle", 32'(dut_idle[0]), 32'h1);
        chk("rst_out_lo", 32'(dut_out[1]), 32'hF);

        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 2'(k));
            chk($sformatf("sweep_hi[%0d]", k), 32'(dut_out[0]), 32'(HI_TBL[k]));
            chk($sformatf("sweep_lo[%0d]", k), 32'(dut_out[1]), 32'(LO_TBL[k]));
            chk($sformatf("sweep_valid[%0d]", k), 32'(dut_val[0]), 32'h1);
        end
        chk("sweep_final", 32'(dut_out[0]), 32'h8);

        step(1'b1, 1'b1, 2'b10);
        chk("gate_first", 32'(dut_out[0]), 32'h4);
        chk("gate_first_hold", 32'(dut_out[2]), 32'h4);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 2'(k));
            chk($sformatf("gate_nohold[%0d]", k), 32'(dut_out[0]), 32'h0);
            chk($sformatf("gate_hold[%0d]", k), 32'(dut_out[2]), 32'h4);
            chk($sformatf("gate_hold_lo[%0d]", k), 32'(dut_out[3]), 32'hB);
            chk($sformatf("gate_valid[%0d]", k), 32'(dut_val[2]), 32'h0);
        end

        step(1'b1, 1'b1, 2'b01);
        step(1'b1, 1'b1, 2'b11);
        step(1'b0, 1'b1, 2'b10);
        chk("midrst_out", 32'(dut_out[0]), 32'h0);
        chk("midrst_out_hold", 32'(dut_out[2]), 32'h0);
        chk("midrst_valid", 32'(dut_val[0]), 32'h0);
        step(1'b1, 1'b1, 2'b10);
        chk("resume_out", 32'(dut_out[0]), 32'h4);
        chk("resume_valid", 32'(dut_val[0]), 32'h1);

        for (int n = 0; n < 1000; n++)
            step(($urandom_range(15) != 0), ($urandom_range(3) != 0), 2'($urandom_range(3)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
